// File: rtl/mii_tx_arbiter.sv
// Frame-level arbiter sharing one MII MAC transmit path between two
// AXI-Stream byte sources. A grant lasts for a whole frame. The arbiter then
// waits for the MAC to finish driving mii_en and holds an inter-frame gap
// before it arbitrates again.
module mii_tx_arbiter #(
  parameter int IFG_CYCLES    = 24,
  parameter int DRAIN_TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        aresetn,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic        s0_tuser,
  input  logic        s0_tlast,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic        s1_tuser,
  input  logic        s1_tlast,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  input  logic        mii_en,
  output logic [1:0]  grant,
  output logic [15:0] frames0,
  output logic [15:0] frames1
);

  // A zero-length gap or timeout would give a zero-width counter, so keep 1 bit.
  localparam int GW = (IFG_CYCLES > 0)    ? $clog2(IFG_CYCLES + 1)    : 1;
  localparam int DW = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;      // most recently served port index
  logic [15:0]     frames0_q, frames0_d;
  logic [15:0]     frames1_q, frames1_d;
  logic            seen_q, seen_d;      // MAC has started transmitting this frame
  logic [DW-1:0]   drain_q, drain_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            pick;

  // State and counter registers with synchronous reset; port 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      frames0_q <= 16'd0;
      frames1_q <= 16'd0;
      seen_q    <= 1'b0;
      drain_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
      seen_q    <= seen_d;
      drain_q   <= drain_d;
      gap_q     <= gap_d;
    end
  end

  // Zero-latency datapath mux: only the owner of SEND sees the MAC; all else is held off.
  always_comb begin
    m_tdata   = 8'd0;
    m_tvalid  = 1'b0;
    m_tuser   = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    if (state_q == SEND) begin
      if (last_q) begin
        m_tdata   = s1_tdata;
        m_tvalid  = s1_tvalid;
        m_tuser   = s1_tuser;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
      end else begin
        m_tdata   = s0_tdata;
        m_tvalid  = s0_tvalid;
        m_tuser   = s0_tuser;
        m_tlast   = s0_tlast;
        s0_tready = m_tready;
      end
    end
  end

  // Next-state logic: round-robin grant, frame completion, MAC drain and gap timing.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    frames0_d = frames0_q;
    frames1_d = frames1_q;
    seen_d    = seen_q;
    drain_d   = drain_q;
    gap_d     = gap_q;
    pick      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          pick    = (s0_tvalid && s1_tvalid) ? ~last_q : s1_tvalid;
          last_d  = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          seen_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        seen_d = seen_q | mii_en;
        if (m_tvalid && m_tready && m_tlast) begin
          if (last_q) frames1_d = frames1_q + 16'd1;
          else        frames0_d = frames0_q + 16'd1;
          grant_d = 2'b00;
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        seen_d = seen_q | mii_en;
        // A MAC that never raises mii_en must not wedge the arbiter.
        if ((seen_q && !mii_en) || (drain_q == DRAIN_LAST)) begin
          gap_d   = '0;
          state_d = GAP;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      GAP: begin
        if ((IFG_CYCLES == 0) || (gap_q == GAP_LAST)) state_d = IDLE;
        else                                          gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant   = grant_q;
  assign frames0 = frames0_q;
  assign frames1 = frames1_q;

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Directed bench for mii_tx_arbiter: reset, single long frame, contention,
// stalls, drain timeout, frame counter wrap and tuser pass-through.
module tb_mii_tx_arbiter;

  logic        clock = 1'b0;
  logic        aresetn;
  logic [7:0]  s0_tdata, s1_tdata, m_tdata;
  logic        s0_tvalid, s0_tready, s0_tuser, s0_tlast;
  logic        s1_tvalid, s1_tready, s1_tuser, s1_tlast;
  logic        m_tvalid, m_tready, m_tuser, m_tlast, mii_en;
  logic [1:0]  grant;
  logic [15:0] frames0, frames1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_f0 = 16'd0;
  logic [15:0] exp_f1 = 16'd0;

  mii_tx_arbiter #(.IFG_CYCLES(24), .DRAIN_TIMEOUT(1023)) dut (
    .clock(clock), .aresetn(aresetn),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .mii_en(mii_en),
    .grant(grant), .frames0(frames0), .frames1(frames1)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Ticks until a grant appears (bounded), then checks latency and owner.
  task automatic wait_grant(input int exp_w, input logic [1:0] exp_g);
    int w = 0;
    while (grant === 2'b00 && w < 2000) begin
      tick;
      w++;
    end
    chk("grant_latency", 32'(w), 32'(exp_w));
    chk("grant_owner", 32'(grant), 32'(exp_g));
  endtask

  // One frame of nb beats from port p; port 0 sends b, port 1 sends 0x80|b.
  // Ends with a short mii_en pulse, leaving the current cycle as the fall cycle.
  task automatic do_frame(input int p, input int nb, input int exp_w);
    wait_grant(exp_w, (p != 0) ? 2'b10 : 2'b01);
    for (int b = 0; b < nb; b++) begin
      s0_tdata = 8'(b);
      s1_tdata = 8'h80 | 8'(b);
      s0_tlast = (b == nb - 1);
      s1_tlast = (b == nb - 1);
      s0_tuser = 1'b0;
      s1_tuser = 1'b0;
      m_tready = 1'b1;
      #1;
      chk("frame_data", 32'(m_tdata), ((p != 0) ? 32'h80 : 32'h0) + 32'(b));
      chk("frame_last", 32'(m_tlast), 32'(b == nb - 1));
      chk("other_ready", 32'((p != 0) ? s0_tready : s1_tready), 32'h0);
      tick;
    end
    if (p != 0) exp_f1 = exp_f1 + 16'd1;
    else        exp_f0 = exp_f0 + 16'd1;
    chk("frames0", 32'(frames0), 32'(exp_f0));
    chk("frames1", 32'(frames1), 32'(exp_f1));
    chk("grant_clear", 32'(grant), 32'h0);
    chk("drain_valid", 32'(m_tvalid), 32'h0);
    mii_en = 1'b1;
    tick;
    mii_en = 1'b0;
  endtask

  initial begin
    int  b;
    logic v, r;
    aresetn = 1'b0;
    s0_tdata = 8'h00; s0_tvalid = 1'b1; s0_tuser = 1'b0; s0_tlast = 1'b0;
    s1_tdata = 8'h00; s1_tvalid = 1'b1; s1_tuser = 1'b0; s1_tlast = 1'b0;
    m_tready = 1'b0;
    mii_en   = 1'b0;

    // Reset held 3 cycles with both sources valid.
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_mvalid", 32'(m_tvalid), 32'h0);
      chk("rst_ready", 32'({s0_tready, s1_tready}), 32'h0);
      chk("rst_frames", 32'({frames0, frames1}), 32'h0);
    end
    aresetn  = 1'b1;
    s0_tdata = 8'hA5;
    s0_tlast = 1'b1;
    m_tready = 1'b1;
    tick;
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_mvalid", 32'(m_tvalid), 32'h1);
    chk("first_data", 32'(m_tdata), 32'hA5);
    chk("first_ready0", 32'(s0_tready), 32'h1);
    chk("first_ready1", 32'(s1_tready), 32'h0);
    tick;
    exp_f0 = 16'd1;
    chk("first_frames0", 32'(frames0), 32'(exp_f0));
    chk("drain_holdoff", 32'(s1_tready), 32'h0);
    chk("drain_grant", 32'(grant), 32'h0);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    mii_en = 1'b1;
    tick;
    mii_en = 1'b0;
    repeat (26) tick;

    // 64-byte frame on port 1; mii_en rises 10 beats in, falls 40 cycles after tlast.
    s1_tvalid = 1'b1;
    s1_tdata  = 8'h10;
    s1_tlast  = 1'b0;
    wait_grant(1, 2'b10);
    for (int i = 0; i < 64; i++) begin
      s1_tdata = 8'h10 + 8'(i);
      s1_tlast = (i == 63);
      mii_en   = (i >= 10);
      #1;
      chk("long_data", 32'(m_tdata), 32'h10 + 32'(i));
      chk("long_valid", 32'(m_tvalid), 32'h1);
      chk("long_last", 32'(m_tlast), 32'(i == 63));
      tick;
    end
    exp_f1 = 16'd1;
    chk("long_frames1", 32'(frames1), 32'(exp_f1));
    s1_tvalid = 1'b0;
    repeat (39) tick;
    mii_en = 1'b0;

    // Contention: both ports stream; grants alternate starting at port 0,
    // each 24+2 cycles after the mii_en fall.
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    for (int k = 0; k < 6; k++) do_frame(k % 2, 4, 26);

    // Stall: port 0 frame with random tready and tvalid gaps while port 1 waits.
    s1_tdata = 8'hEE;
    s1_tlast = 1'b1;
    s0_tlast = 1'b0;
    wait_grant(26, 2'b01);
    b = 0;
    for (int c = 0; c < 400 && b < 8; c++) begin
      v = ($urandom_range(3, 0) != 0);
      r = ($urandom_range(2, 0) != 0);
      s0_tvalid = v;
      s0_tdata  = 8'h40 + 8'(b);
      s0_tlast  = (b == 7);
      m_tready  = r;
      #1;
      chk("stall_ready1", 32'(s1_tready), 32'h0);
      chk("stall_mvalid", 32'(m_tvalid), 32'(v));
      chk("stall_grant", 32'(grant), 32'h1);
      if (v) chk("stall_data", 32'(m_tdata), 32'h40 + 32'(b));
      if (v && r) b++;
      tick;
    end
    chk("stall_beats", 32'(b), 32'd8);
    exp_f0 = exp_f0 + 16'd1;
    chk("stall_frames0", 32'(frames0), 32'(exp_f0));
    s0_tvalid = 1'b0;
    m_tready  = 1'b1;
    mii_en = 1'b1;
    tick;
    mii_en = 1'b0;
    do_frame(1, 1, 26);
    s1_tvalid = 1'b0;
    repeat (26) tick;

    // Drain timeout: mii_en never rises; 1023 DRAIN + 24 GAP + IDLE before next grant.
    s0_tvalid = 1'b1;
    s0_tlast  = 1'b1;
    s0_tdata  = 8'h5A;
    wait_grant(1, 2'b01);
    #1;
    chk("to_data", 32'(m_tdata), 32'h5A);
    tick;
    exp_f0 = exp_f0 + 16'd1;
    chk("to_frames0", 32'(frames0), 32'(exp_f0));
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b1;
    do_frame(1, 1, 1048);
    s1_tvalid = 1'b0;
    repeat (26) tick;

    // Counter wrap and tuser pass-through on the last beat.
    force dut.frames0_q = 16'hFFFF;
    tick;
    tick;
    release dut.frames0_q;
    tick;
    exp_f0 = 16'hFFFF;
    chk("wrap_preset", 32'(frames0), 32'(exp_f0));
    s0_tvalid = 1'b1;
    s0_tlast  = 1'b0;
    s0_tuser  = 1'b0;
    s0_tdata  = 8'h31;
    wait_grant(1, 2'b01);
    #1;
    chk("wrap_tuser0", 32'(m_tuser), 32'h0);
    tick;
    s0_tdata = 8'h32;
    s0_tuser = 1'b1;
    s0_tlast = 1'b1;
    #1;
    chk("wrap_tuser1", 32'(m_tuser), 32'h1);
    chk("wrap_last", 32'(m_tlast), 32'h1);
    chk("wrap_data", 32'(m_tdata), 32'h32);
    tick;
    exp_f0 = exp_f0 + 16'd1;
    s0_tvalid = 1'b0;
    chk("wrap_frames0", 32'(frames0), 32'(exp_f0));
    chk("wrap_frames1", 32'(frames1), 32'(exp_f1));
    chk("wrap_tuser_idle", 32'(m_tuser), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
